lsu_ctrl: RTL and testbench

- Load/store sequencer between the core's memory stage and the single-port data memory bus.
- Accepts one request at a time with a valid/ready handshake and checks alignment.
- Drives one word-aligned bus transaction using an internal byte_lane instance for byte enables, store replication and load extraction/extension.
- Returns one response (data or fault) to the core with a valid/ready handshake; includes a bus timeout watchdog.

---
 rtl/lsu_ctrl.sv | 271 +++++++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: accepts one core request, runs one word-aligned
// transaction on the single-port data bus and returns one response.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A source holds valid and its payload stable until that edge;
// ready may be used combinationally by the source.
//
// Size encoding on req_size: 2'b00 byte, 2'b01 half, 2'b10 word (2'b11 acts
// as word).

// Byte-lane steering: byte enables and store replication for the request
// side, lane extraction plus sign/zero extension for the load side.
module byte_lane (
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Select the addressed byte / halfword of the read word.
    always_comb begin
        lane_b = 8'h00;
        case (offset)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    // Enables, replication and extension per access size.
    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
        case (size)
            SIZE_BYTE: begin
                be        = 4'b0001 << offset;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{~is_unsigned & lane_b[7]}}, lane_b};
            end
            SIZE_HALF: begin
                be        = offset[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{~is_unsigned & lane_h[15]}}, lane_h};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
        endcase
    end
endmodule

module lsu_ctrl #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_fault,
    output logic [1:0]       resp_fault_code,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
);
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_MISALIGN = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT  = 2'b10;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [1:0]       off_q, off_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic             resp_fault_q, resp_fault_d;
    logic [1:0]       resp_code_q, resp_code_d;

    // One shared lane unit: in IDLE it sees the incoming request, afterwards
    // it sees the captured request so load data can be extracted on ack.
    logic [1:0]  bl_size;
    logic [1:0]  bl_off;
    logic        bl_uns;
    logic [3:0]  bl_be;
    logic [31:0] bl_wrep;
    logic [31:0] bl_rext;
    logic        misaligned;
    logic [CW-1:0] cnt_inc;

    assign bl_size = (state_q == ST_IDLE) ? req_size      : size_q;
    assign bl_off  = (state_q == ST_IDLE) ? req_addr[1:0] : off_q;
    assign bl_uns  = (state_q == ST_IDLE) ? req_unsigned  : uns_q;

    byte_lane u_byte_lane (
        .size        (bl_size),
        .offset      (bl_off),
        .is_unsigned (bl_uns),
        .wdata       (req_wdata),
        .rdata       (mem_rdata),
        .be          (bl_be),
        .wdata_rep   (bl_wrep),
        .rdata_ext   (bl_rext)
    );

    assign misaligned = ((req_size == SIZE_HALF) && req_addr[0]) ||
                        ((req_size != SIZE_HALF) && (req_size != SIZE_BYTE) &&
                         (req_addr[1:0] != 2'b00));
    assign cnt_inc    = cnt_q + CW'(1);

    // Next-state and next-output computation for the IDLE/BUS/RESP sequencer.
    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_fault_d = resp_fault_q;
        resp_code_d  = resp_code_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    size_d = req_size;
                    uns_d  = req_unsigned;
                    off_d  = req_addr[1:0];
                    if (misaligned) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = '0;
                        resp_fault_d = 1'b1;
                        resp_code_d  = CODE_MISALIGN;
                    end else begin
                        state_d     = ST_BUS;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[WIDTH-1:2], 2'b00};
                        mem_wdata_d = bl_wrep;
                        mem_be_d    = req_we ? bl_be : 4'b0000;
                    end
                end
            end
            ST_BUS: begin
                if (mem_ack) begin
                    // Ack has priority over a coincident timeout.
                    state_d      = ST_RESP;
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = mem_we_q ? '0 : bl_rext;
                    resp_fault_d = 1'b0;
                    resp_code_d  = CODE_NONE;
                end else if ((TIMEOUT_CYCLES != 0) &&
                             (cnt_inc == CW'(TIMEOUT_CYCLES))) begin
                    state_d      = ST_RESP;
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                    resp_fault_d = 1'b1;
                    resp_code_d  = CODE_TIMEOUT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = '0;
                    resp_fault_d = 1'b0;
                    resp_code_d  = CODE_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= 4'b0000;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_fault_q <= 1'b0;
            resp_code_q  <= CODE_NONE;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
            resp_code_q  <= resp_code_d;
        end
    end

    assign req_ready       = (state_q == ST_IDLE);
    assign mem_req         = mem_req_q;
    assign mem_we          = mem_we_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_be          = mem_be_q;
    assign resp_valid      = resp_valid_q;
    assign resp_rdata      = resp_rdata_q;
    assign resp_fault      = resp_fault_q;
    assign resp_fault_code = resp_code_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed cases plus randomized accesses, each checked
// against a reference model built from address/size arithmetic.
module tb_lsu_ctrl;
    localparam int TMO = 4;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [1:0]  resp_fault_code;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;
    logic [33:0] exp_q[$];

    lsu_ctrl #(.WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_addr        (req_addr),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_rdata      (resp_rdata),
        .resp_fault      (resp_fault),
        .resp_fault_code (resp_fault_code),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_be          (mem_be),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model helpers.
    function automatic bit model_misaligned(input logic [31:0] addr, input logic [1:0] size);
        if (size == SZ_H) return addr[0];
        if (size == SZ_W) return (addr % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [1:0] size);
        int off = addr % 4;
        if (size == SZ_B) return 4'(1 << off);
        if (size == SZ_H) return (off >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wrep(input logic [31:0] wdata, input logic [1:0] size);
        if (size == SZ_B) return (wdata & 32'hFF) * 32'h0101_0101;
        if (size == SZ_H) return (wdata & 32'hFFFF) * 32'h0001_0001;
        return wdata;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                               input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        logic [31:0] v;
        sh = rdata >> (8 * (addr % 4));
        if (size == SZ_B) begin
            v = sh & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == SZ_H) begin
            v = sh & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    // One full access. waits < 0 means the bus never acks.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                             input logic uns, input logic [31:0] wdata, input logic [31:0] rdata,
                             input int waits, input int rdy_delay, input bit poke_req);
        logic [33:0] exp;
        logic [31:0] held;
        bit          mis;
        int          hi;
        mis = model_misaligned(addr, size);
        if (mis)
            exp = {2'b01, 32'h0};
        else if (waits < 0 || waits >= TMO)
            exp = {2'b10, 32'h0};
        else if (we)
            exp = {2'b00, 32'h0};
        else
            exp = {2'b00, model_load(rdata, addr, size, uns)};
        exp_q.push_back(exp);

        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = $urandom;
        check("req_ready_busy", 32'(req_ready), 32'd0);
        if (mis) begin
            check("mis_no_mem_req", 32'(mem_req), 32'd0);
        end else begin
            check("mem_req", 32'(mem_req), 32'd1);
            check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
            check("mem_we", 32'(mem_we), 32'(we));
            check("mem_be", 32'(mem_be), we ? 32'(model_be(addr, size)) : 32'd0);
            if (we) check("mem_wdata", mem_wdata, model_wrep(wdata, size));
            if (waits >= 0 && waits < TMO) begin
                for (int i = 0; i < waits; i++) begin
                    @(posedge clk); #1;
                    check("mem_req_hold", 32'(mem_req), 32'd1);
                    check("mem_addr_hold", mem_addr, addr & 32'hFFFF_FFFC);
                end
                mem_ack = 1'b1; mem_rdata = rdata;
                @(posedge clk); #1;
                mem_ack = 1'b0; mem_rdata = $urandom;
                check("mem_req_drop", 32'(mem_req), 32'd0);
            end else begin
                hi = 0;
                while (mem_req && hi < 50) begin
                    hi++;
                    @(posedge clk); #1;
                end
                check("timeout_req_cycles", 32'(hi), 32'(TMO));
            end
        end

        exp = exp_q.pop_front();
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_fault", 32'(resp_fault), 32'(exp[33:32] != 2'b00));
        check("resp_code", 32'(resp_fault_code), 32'(exp[33:32]));
        check("resp_rdata", resp_rdata, exp[31:0]);
        held = resp_rdata;

        if (poke_req) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = $urandom & 32'hFFFF_FFFC;
            req_size = SZ_W;
        end
        for (int i = 0; i < rdy_delay; i++) begin
            @(posedge clk); #1;
            check("resp_valid_hold", 32'(resp_valid), 32'd1);
            check("resp_rdata_hold", resp_rdata, held);
            check("req_ready_hold", 32'(req_ready), 32'd0);
            if (poke_req) check("no_mem_req_hold", 32'(mem_req), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("resp_done", 32'(resp_valid), 32'd0);
        check("req_ready_after", 32'(req_ready), 32'd1);
        if (poke_req) begin
            check("poke_not_taken", 32'(mem_req), 32'd0);
            req_valid = 1'b0;
        end
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        int          w;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = SZ_W;
        req_unsigned = 1'b0; req_wdata = '0; resp_ready = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_resp_code", 32'(resp_fault_code), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);

        // Directed cases.
        do_access(1'b1, 32'h1003, SZ_B, 1'b0, 32'h0000_00A5, 32'h0, 2, 0, 1'b0);
        do_access(1'b0, 32'h2002, SZ_H, 1'b0, 32'h0, 32'h8001_1234, 0, 0, 1'b0);
        do_access(1'b0, 32'h2002, SZ_H, 1'b1, 32'h0, 32'h8001_1234, 0, 0, 1'b0);
        do_access(1'b0, 32'h3001, SZ_W, 1'b0, 32'h0, 32'h0, 0, 0, 1'b0);
        do_access(1'b0, 32'h3003, SZ_H, 1'b0, 32'h0, 32'h0, 0, 0, 1'b0);
        do_access(1'b0, 32'h3003, SZ_B, 1'b0, 32'h0, 32'h9A00_0000, 1, 0, 1'b0);
        do_access(1'b0, 32'h4000, SZ_W, 1'b0, 32'h0, 32'h0, -1, 0, 1'b0);
        // Late ack after the timeout must be ignored.
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(posedge clk); #1;
        check("late_ack_ready", 32'(req_ready), 32'd1);
        check("late_ack_no_resp", 32'(resp_valid), 32'd0);
        check("late_ack_no_req", 32'(mem_req), 32'd0);
        // Ack and timeout on the same cycle: ack wins.
        do_access(1'b0, 32'h5000, SZ_W, 1'b0, 32'h0, 32'hCAFE_F00D, TMO - 1, 0, 1'b0);
        // Held response with a competing request.
        do_access(1'b0, 32'h6000, SZ_W, 1'b0, 32'h0, 32'h1234_5678, 1, 5, 1'b1);

        // Reset while the bus request is outstanding.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h7000; req_size = SZ_W;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("pre_rst_mem_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_mem_req", 32'(mem_req), 32'd0);
        check("async_rst_resp", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);
        do_access(1'b0, 32'h0000_0001, SZ_B, 1'b1, 32'h0, 32'h0000_FF00, 0, 0, 1'b0);

        // Randomized accesses.
        for (int n = 0; n < 150; n++) begin
            sz = 2'($urandom_range(0, 2));
            a  = $urandom;
            if ($urandom_range(0, 1) == 0) a = a & ~((sz == SZ_W) ? 32'h3 : (sz == SZ_H) ? 32'h1 : 32'h0);
            w  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TMO - 1));
            do_access(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom, $urandom,
                      w, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
